// File: rtl/servo_pkg.sv
// servo_pkg: widths, FSM state encoding and default ratios shared by the
// servo command sequencer and servo_ctrl.
package servo_pkg;

    localparam int RATIO_W = 8;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2
    } seq_state_e;

    // Default ratios shared with servo_ctrl
    localparam logic [RATIO_W-1:0] PARK_RATIO_DEF = 8'd20;
    localparam logic [RATIO_W-1:0] MIN_RATIO_DEF  = 8'd10;
    localparam logic [RATIO_W-1:0] MAX_RATIO_DEF  = 8'd60;

    // Limit a ratio to the closed range [lo, hi]
    function automatic logic [RATIO_W-1:0] clamp_ratio(
        input logic [RATIO_W-1:0] r,
        input logic [RATIO_W-1:0] lo,
        input logic [RATIO_W-1:0] hi
    );
        if (r < lo) begin
            return lo;
        end
        if (r > hi) begin
            return hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_cmd_fifo.sv
// servo_cmd_fifo: synchronous command FIFO for servo_cmd_seq.
// Head entry is presented combinationally on rd_data; flush empties the
// FIFO at the next edge and overrides push and pop.
module servo_cmd_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH[PTR_W:0]);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Qualify requests so overflow/underflow can never corrupt pointers
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/servo_cmd_seq.sv
// servo_cmd_seq: buffers servo position commands and plays them back to
// servo_ctrl, holding each target for its dwell time.
// Optional build macro SERVO_SEQ_CLAMP_EN clamps popped ratios to
// [MIN_RATIO, MAX_RATIO] and pulses clamp_hit when a value was changed.
module servo_cmd_seq
    import servo_pkg::*;
#(
    parameter int                 FIFO_DEPTH = 4,
    parameter int                 DWELL_W    = 16,
    parameter logic [RATIO_W-1:0] PARK_RATIO = PARK_RATIO_DEF,
    parameter logic [RATIO_W-1:0] MIN_RATIO  = MIN_RATIO_DEF,
    parameter logic [RATIO_W-1:0] MAX_RATIO  = MAX_RATIO_DEF
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [RATIO_W-1:0]            cmd_ratio,
    input  logic [DWELL_W-1:0]            cmd_dwell,
    input  logic                          seq_enable,
    input  logic                          abort,
    output logic                          pwm_enable,
    output logic [RATIO_W-1:0]            start_pwm_ratio,
    output logic [RATIO_W-1:0]            target_pwm_ratio,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          clamp_hit
);

    localparam int ENTRY_W = RATIO_W + DWELL_W;

    seq_state_e         state_q, state_d;
    logic               pwm_enable_q, pwm_enable_d;
    logic [RATIO_W-1:0] start_q, start_d;
    logic [RATIO_W-1:0] target_q, target_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               clamp_hit_q, clamp_hit_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [RATIO_W-1:0] head_ratio;
    logic [DWELL_W-1:0] head_dwell;
    logic [RATIO_W-1:0] pop_ratio;
    logic               pop_clamped;

    assign cmd_ready = !fifo_full && !abort;
    assign fifo_push = cmd_valid && cmd_ready;

    assign head_ratio = fifo_head[ENTRY_W-1:DWELL_W];
    assign head_dwell = fifo_head[DWELL_W-1:0];

`ifdef SERVO_SEQ_CLAMP_EN
    assign pop_ratio   = clamp_ratio(head_ratio, MIN_RATIO, MAX_RATIO);
    assign pop_clamped = (pop_ratio != head_ratio);
`else
    logic unused_clamp_cfg;
    assign pop_ratio        = head_ratio;
    assign pop_clamped      = 1'b0;
    assign unused_clamp_cfg = ^{MIN_RATIO, MAX_RATIO};
`endif

    servo_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (abort),
        .wr_data ({cmd_ratio, cmd_dwell}),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Sequencer next-state: abort wins, otherwise IDLE -> LOAD -> DWELL
    always_comb begin
        state_d      = state_q;
        pwm_enable_d = pwm_enable_q;
        start_d      = start_q;
        target_d     = target_q;
        dwell_d      = dwell_q;
        clamp_hit_d  = 1'b0;
        fifo_pop     = 1'b0;
        if (abort) begin
            state_d      = IDLE;
            pwm_enable_d = 1'b0;
            start_d      = PARK_RATIO;
            target_d     = PARK_RATIO;
            dwell_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seq_enable && !fifo_empty) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    fifo_pop     = 1'b1;
                    start_d      = target_q;
                    target_d     = pop_ratio;
                    pwm_enable_d = 1'b1;
                    clamp_hit_d  = pop_clamped;
                    // A zero dwell still holds the target for one cycle
                    dwell_d      = (head_dwell == '0) ? DWELL_W'(1) : head_dwell;
                    state_d      = DWELL;
                end
                DWELL: begin
                    if (dwell_q <= DWELL_W'(1)) begin
                        dwell_d = '0;
                        state_d = (seq_enable && !fifo_empty) ? LOAD : IDLE;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dwell_d = '0;
                end
            endcase
        end
    end

    // Sequencer state and registered servo_ctrl outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pwm_enable_q <= 1'b0;
            start_q      <= PARK_RATIO;
            target_q     <= PARK_RATIO;
            dwell_q      <= '0;
            clamp_hit_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwm_enable_q <= pwm_enable_d;
            start_q      <= start_d;
            target_q     <= target_d;
            dwell_q      <= dwell_d;
            clamp_hit_q  <= clamp_hit_d;
        end
    end

    assign pwm_enable       = pwm_enable_q;
    assign start_pwm_ratio  = start_q;
    assign target_pwm_ratio = target_q;
    assign clamp_hit        = clamp_hit_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_servo_cmd_seq.sv
// tb_servo_cmd_seq: directed, table-driven bench for servo_cmd_seq.
// Expected clamp results follow the SERVO_SEQ_CLAMP_EN build macro.
module tb_servo_cmd_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_ratio = 8'd0;
    logic [15:0] cmd_dwell = 16'd0;
    logic        seq_enable = 1'b0;
    logic        abort = 1'b0;
    logic        pwm_enable;
    logic [7:0]  start_pwm_ratio;
    logic [7:0]  target_pwm_ratio;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        clamp_hit;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef SERVO_SEQ_CLAMP_EN
    localparam logic [7:0] EXP_A    = 8'd10;
    localparam logic [7:0] EXP_B    = 8'd60;
    localparam int         EXP_HITS = 2;
    localparam logic       EXP_HIT  = 1'b1;
`else
    localparam logic [7:0] EXP_A    = 8'd5;
    localparam logic [7:0] EXP_B    = 8'd200;
    localparam int         EXP_HITS = 0;
    localparam logic       EXP_HIT  = 1'b0;
`endif

    servo_cmd_seq dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_ratio        (cmd_ratio),
        .cmd_dwell        (cmd_dwell),
        .seq_enable       (seq_enable),
        .abort            (abort),
        .pwm_enable       (pwm_enable),
        .start_pwm_ratio  (start_pwm_ratio),
        .target_pwm_ratio (target_pwm_ratio),
        .busy             (busy),
        .fifo_count       (fifo_count),
        .clamp_hit        (clamp_hit)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        vld;
        logic [7:0]  ratio;
        logic [15:0] dwell;
        logic        sen;
        logic        abt;
        logic        rdy;
        logic        pwm;
        logic [7:0]  st;
        logic [7:0]  tg;
        logic        bsy;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(
        input logic vld, input logic [7:0] ratio, input logic [15:0] dwell,
        input logic sen, input logic abt, input logic rdy, input logic pwm,
        input logic [7:0] st, input logic [7:0] tg, input logic bsy,
        input logic [2:0] cnt
    );
        vec_t v;
        v.vld = vld; v.ratio = ratio; v.dwell = dwell; v.sen = sen;
        v.abt = abt; v.rdy = rdy; v.pwm = pwm; v.st = st; v.tg = tg;
        v.bsy = bsy; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] r, input logic [15:0] d);
        @(negedge clock);
        cmd_valid = v;
        cmd_ratio = r;
        cmd_dwell = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        seq_enable = 1'b0;
        abort      = 1'b0;
        #1;
        check("rst.async_pwm", pwm_enable, 0);
        check("rst.async_tgt", target_pwm_ratio, 20);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Records every change of target_pwm_ratio over a fixed window
    int         mon_n, mon_hits, mon_fall;
    logic [7:0] mon_tgt[8];
    logic [7:0] mon_st[8];
    int         mon_cyc[8];
    logic       mon_hit[8];

    task automatic monitor(input int cycles);
        logic [7:0] prev;
        logic       prev_busy;
        prev      = target_pwm_ratio;
        prev_busy = busy;
        mon_n = 0; mon_hits = 0; mon_fall = 0;
        for (int k = 0; k < 8; k++) begin
            mon_tgt[k] = 8'd0; mon_st[k] = 8'd0; mon_cyc[k] = 0; mon_hit[k] = 1'b0;
        end
        for (int c = 1; c <= cycles; c++) begin
            step(1'b0, 8'd0, 16'd0);
            if (clamp_hit) mon_hits++;
            if (target_pwm_ratio !== prev) begin
                if (mon_n < 8) begin
                    mon_tgt[mon_n] = target_pwm_ratio;
                    mon_st[mon_n]  = start_pwm_ratio;
                    mon_cyc[mon_n] = c;
                    mon_hit[mon_n] = clamp_hit;
                end
                mon_n++;
            end
            if (prev_busy && !busy && mon_fall == 0) mon_fall = c;
            prev      = target_pwm_ratio;
            prev_busy = busy;
        end
    endtask

    initial begin
        int         bcount;
        int         exp_t[3];
        int         exp_s[3];
        int         exp_c[3];
        int         full_c[4];

        // ---- reset then idle ----
        #2;
        check("rst.pwm", pwm_enable, 0);
        check("rst.count", fifo_count, 0);
        check("rst.clamp_hit", clamp_hit, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("idle.pwm", pwm_enable, 0);
        check("idle.start", start_pwm_ratio, 20);
        check("idle.target", target_pwm_ratio, 20);
        check("idle.ready", cmd_ready, 1);
        check("idle.busy", busy, 0);

        // ---- table: pushes (30,2),(45,1),(25,0) streamed, then abort ----
        //            vld  ratio   dwell   sen  abt  rdy  pwm  st      tg      bsy  cnt
        vecs[0]  = mk(1'b1, 8'd30, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd20, 8'd20, 1'b0, 3'd1);
        vecs[1]  = mk(1'b1, 8'd45, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd20, 8'd20, 1'b1, 3'd2);
        vecs[2]  = mk(1'b1, 8'd25, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd20, 8'd30, 1'b1, 3'd2);
        vecs[3]  = mk(1'b0, 8'd0,  16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd20, 8'd30, 1'b1, 3'd2);
        vecs[4]  = mk(1'b0, 8'd0,  16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd20, 8'd30, 1'b1, 3'd2);
        vecs[5]  = mk(1'b0, 8'd0,  16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd30, 8'd45, 1'b1, 3'd1);
        vecs[6]  = mk(1'b0, 8'd0,  16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd30, 8'd45, 1'b1, 3'd1);
        vecs[7]  = mk(1'b0, 8'd0,  16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd45, 8'd25, 1'b1, 3'd0);
        vecs[8]  = mk(1'b0, 8'd0,  16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd45, 8'd25, 1'b0, 3'd0);
        vecs[9]  = mk(1'b0, 8'd0,  16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd45, 8'd25, 1'b0, 3'd0);
        vecs[10] = mk(1'b1, 8'd99, 16'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd20, 8'd20, 1'b0, 3'd0);
        vecs[11] = mk(1'b0, 8'd0,  16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd20, 8'd20, 1'b0, 3'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            cmd_valid  = vecs[i].vld;
            cmd_ratio  = vecs[i].ratio;
            cmd_dwell  = vecs[i].dwell;
            seq_enable = vecs[i].sen;
            abort      = vecs[i].abt;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d.ready", i),  cmd_ready,        vecs[i].rdy);
            check($sformatf("vec%0d.pwm", i),    pwm_enable,       vecs[i].pwm);
            check($sformatf("vec%0d.start", i),  start_pwm_ratio,  vecs[i].st);
            check($sformatf("vec%0d.target", i), target_pwm_ratio, vecs[i].tg);
            check($sformatf("vec%0d.busy", i),   busy,             vecs[i].bsy);
            check($sformatf("vec%0d.count", i),  fifo_count,       vecs[i].cnt);
        end
        abort = 1'b0;

        // ---- single command (50,100): 2-edge latency, 101 busy cycles ----
        do_reset();
        seq_enable = 1'b1;
        step(1'b1, 8'd50, 16'd100);
        check("single.busy_push", busy, 0);
        step(1'b0, 8'd0, 16'd0);
        check("single.busy_load", busy, 1);
        check("single.tgt_load", target_pwm_ratio, 20);
        step(1'b0, 8'd0, 16'd0);
        check("single.target", target_pwm_ratio, 50);
        check("single.start", start_pwm_ratio, 20);
        check("single.pwm", pwm_enable, 1);
        bcount = 2;
        for (int g = 0; g < 300 && busy; g++) begin
            step(1'b0, 8'd0, 16'd0);
            if (busy) bcount++;
        end
        check("single.busy_cycles", bcount, 101);
        check("single.hold_tgt", target_pwm_ratio, 50);
        check("single.hold_pwm", pwm_enable, 1);
        check("single.idle", busy, 0);

        // ---- back-to-back (30,10),(45,5),(25,0) ----
        do_reset();
        step(1'b1, 8'd30, 16'd10);
        step(1'b1, 8'd45, 16'd5);
        step(1'b1, 8'd25, 16'd0);
        check("b2b.count", fifo_count, 3);
        seq_enable = 1'b1;
        monitor(30);
        exp_t = '{30, 45, 25};
        exp_s = '{20, 30, 45};
        exp_c = '{2, 13, 19};
        check("b2b.changes", mon_n, 3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b.tgt%0d", k), mon_tgt[k], exp_t[k]);
            check($sformatf("b2b.start%0d", k), mon_st[k], exp_s[k]);
            check($sformatf("b2b.cycle%0d", k), mon_cyc[k], exp_c[k]);
        end
        check("b2b.busy_fall", mon_fall, 20);

        // ---- FIFO full: 5th push refused, exactly 4 drained ----
        do_reset();
        step(1'b1, 8'd11, 16'd0);
        step(1'b1, 8'd12, 16'd0);
        step(1'b1, 8'd13, 16'd0);
        step(1'b1, 8'd14, 16'd0);
        check("full.count", fifo_count, 4);
        check("full.ready", cmd_ready, 0);
        step(1'b1, 8'd15, 16'd0);
        check("full.count5", fifo_count, 4);
        seq_enable = 1'b1;
        monitor(20);
        full_c = '{2, 4, 6, 8};
        check("full.drained", mon_n, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("full.tgt%0d", k), mon_tgt[k], 11 + k);
            check($sformatf("full.cycle%0d", k), mon_cyc[k], full_c[k]);
        end
        check("full.final_count", fifo_count, 0);
        check("full.final_tgt", target_pwm_ratio, 14);

        // ---- abort mid-DWELL with 2 queued, same-cycle push dropped ----
        do_reset();
        seq_enable = 1'b1;
        step(1'b1, 8'd40, 16'd20);
        step(1'b1, 8'd41, 16'd20);
        step(1'b1, 8'd42, 16'd20);
        step(1'b0, 8'd0, 16'd0);
        step(1'b0, 8'd0, 16'd0);
        check("abort.pre_count", fifo_count, 2);
        check("abort.pre_tgt", target_pwm_ratio, 40);
        check("abort.pre_busy", busy, 1);
        @(negedge clock);
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_ratio = 8'd43;
        cmd_dwell = 16'd5;
        #1;
        check("abort.ready_low", cmd_ready, 0);
        @(posedge clock);
        #1;
        check("abort.pwm", pwm_enable, 0);
        check("abort.target", target_pwm_ratio, 20);
        check("abort.start", start_pwm_ratio, 20);
        check("abort.count", fifo_count, 0);
        check("abort.busy", busy, 0);
        abort = 1'b0;
        monitor(6);
        check("abort.after_changes", mon_n, 0);
        check("abort.after_count", fifo_count, 0);
        check("abort.after_pwm", pwm_enable, 0);

        // ---- clamp: ratios 5 and 200 ----
        do_reset();
        step(1'b1, 8'd5, 16'd3);
        step(1'b1, 8'd200, 16'd3);
        seq_enable = 1'b1;
        monitor(15);
        check("clamp.changes", mon_n, 2);
        check("clamp.tgt0", mon_tgt[0], EXP_A);
        check("clamp.tgt1", mon_tgt[1], EXP_B);
        check("clamp.hit0", mon_hit[0], EXP_HIT);
        check("clamp.hit1", mon_hit[1], EXP_HIT);
        check("clamp.cycle1", mon_cyc[1], 6);
        check("clamp.pulses", mon_hits, EXP_HITS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
